// File: rtl/lightcube_pkg.sv
// rtl/lightcube_pkg.sv - shared constants and receiver state encoding for the light-cube frame path
package lightcube_pkg;

    localparam logic [7:0] SOF_BYTE    = 8'hA5;
    localparam int         FRAME_BYTES = 64;
    localparam int         FRAME_W     = 512;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CSUM = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        DATA = ST_DATA,
        CSUM = ST_CSUM
    } state_t;

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte watchdog; expired pulses on the terminal count unless a byte clears it
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_count;
    logic          w_terminal;

    assign w_terminal = (r_count == TERMINAL);
    // A byte arriving on the terminal cycle wins over the timeout.
    assign expired    = en && !clr && w_terminal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr || !en || w_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - assembles SOF-framed 64-byte light-cube frames and commits them on a good checksum
module uart_frame_rx
    import lightcube_pkg::state_t, lightcube_pkg::IDLE, lightcube_pkg::DATA, lightcube_pkg::CSUM;
#(
    parameter logic [7:0] SOF            = lightcube_pkg::SOF_BYTE,
    parameter int         FRAME_BYTES    = lightcube_pkg::FRAME_BYTES,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk_100M,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic [FRAME_BYTES*8-1:0] frame,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int            CW   = $clog2(FRAME_BYTES);
    localparam int            FW   = FRAME_BYTES * 8;
    localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_sum;
    logic [FW-1:0] r_staging;
    logic [FW-1:0] r_frame;
    logic          r_frame_valid;
    logic          r_frame_err;

    logic          w_start;
    logic          w_store;
    logic          w_commit;
    logic          w_err;
    logic          w_expired;
    logic          w_timer_en;

    assign w_timer_en = (r_state != IDLE);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_100M),
        .rst    (rst),
        .clr    (byte_valid),
        .en     (w_timer_en),
        .expired(w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (byte_valid && byte_data == SOF) begin
                    w_start     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    w_store = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = CSUM;
                    end
                end else if (w_expired) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    w_commit    = (byte_data == r_sum);
                    w_err       = (byte_data != r_sum);
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sum         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_valid <= w_commit;
            r_frame_err   <= w_err;
            if (w_start) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else if (w_store) begin
                r_cnt <= r_cnt + 1'b1;
                r_sum <= r_sum + byte_data;
            end
            // Whole-frame copy in one edge so the scanner never sees a mix of frames.
            if (w_commit) begin
                r_frame <= r_staging;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (w_store) begin
            r_staging[{r_cnt, 3'b000} +: 8] <= byte_data;
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed and randomized frames checked against a byte-level reference model
module tb_uart_frame_rx;

    localparam int TIMEOUT = 1000;
    localparam int NB      = 64;

    typedef logic [7:0] frame_t [NB];

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           byte_valid = 1'b0;
    logic [7:0]     byte_data = 8'h00;
    logic [NB*8-1:0] frame;
    logic           frame_valid;
    logic           frame_err;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_cnt  = 0;
    int fe_cnt  = 0;
    int exp_fv  = 0;
    int exp_fe  = 0;
    logic [NB*8-1:0] exp_frame = '0;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .SOF           (8'hA5),
        .FRAME_BYTES   (NB),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_100M   (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (rst) begin
            if (frame_valid) fv_cnt++;
            if (frame_err)   fe_cnt++;
            if (frame_valid || frame_err) begin
                n_tests++;
                assert (!(frame_valid && frame_err))
                else begin
                    n_fail++;
                    $error("FAIL excl obs=valid&err exp=exclusive");
                end
            end
        end
    end

    task automatic check(input string tag, input logic [NB*8-1:0] obs, input logic [NB*8-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*8-1:0] pack(input frame_t b);
        logic [NB*8-1:0] f;
        for (int k = 0; k < NB; k++) f[8*k +: 8] = b[k];
        return f;
    endfunction

    function automatic logic [7:0] model_sum(input frame_t b);
        int s = 0;
        for (int k = 0; k < NB; k++) s += int'(b[k]);
        return 8'(s % 256);
    endfunction

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    // stall_idx: before byte stall_idx (NB = checksum) hold the line idle until the timer's terminal cycle.
    task automatic send_frame(input frame_t b, input logic [7:0] cs, input int max_gap,
                              input int stall_idx, input string tag);
        logic ok;
        ok = (cs == model_sum(b));
        drive(1'b1, 8'hA5);
        for (int i = 0; i <= NB; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            if (i == stall_idx) idle(TIMEOUT - 1);
            drive(1'b1, (i < NB) ? b[i] : cs);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (ok) begin
            exp_frame = pack(b);
            exp_fv++;
        end else begin
            exp_fe++;
        end
        check({tag, "_fv"}, frame_valid, ok);
        check({tag, "_fe"}, frame_err, !ok);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame"}, frame, exp_frame);
    endtask

    initial begin
        frame_t b;
        logic [7:0] g;
        int k;

        repeat (3) @(negedge clk);
        check("rst_frame", frame, '0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < NB; i++) b[i] = 8'(i);
        send_frame(b, 8'hE0, 0, -1, "good");
        check("good_lo", frame[7:0], 8'h00);
        check("good_hi", frame[511:504], 8'h3F);

        send_frame(b, 8'hE1, 0, -1, "badcs");

        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        check("garbage_busy", busy, 1'b0);
        for (int i = 0; i < NB; i++) b[i] = 8'hA5;
        send_frame(b, 8'h40, 2, -1, "sof_in_data");

        drive(1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom));
        k = 0;
        while (k < TIMEOUT + 100) begin
            @(negedge clk);
            byte_valid = 1'b0;
            k++;
            if (frame_err) break;
        end
        // Error rises on the TIMEOUT-th edge after the edge that took the last byte.
        check("to_latency", k, TIMEOUT + 1);
        check("to_busy", busy, 1'b0);
        check("to_frame", frame, exp_frame);
        exp_fe++;
        @(negedge clk);
        check("to_pulse_width", frame_err, 1'b0);
        for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
        send_frame(b, model_sum(b), 3, -1, "after_to");

        for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
        send_frame(b, model_sum(b), 0, -1, "b2b");

        drive(1'b1, 8'hA5);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom));
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_frame = '0;
        check("midrst_frame", frame, exp_frame);
        check("midrst_busy", busy, 1'b0);
        check("midrst_fe", frame_err, 1'b0);
        idle(5);
        check("midrst_fe_cnt", fe_cnt, exp_fe);

        for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
        send_frame(b, model_sum(b), 0, 6, "collide_data");
        for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
        send_frame(b, model_sum(b), 0, NB, "collide_csum");

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) begin
                do g = 8'($urandom); while (g == 8'hA5);
                drive(1'b1, g);
            end
            idle($urandom_range(0, 4));
            for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
            g = model_sum(b);
            if ($urandom_range(0, 2) == 0) g = g ^ 8'($urandom_range(1, 255));
            send_frame(b, g, $urandom_range(0, 4), -1, $sformatf("rand%0d", r));
        end

        idle(3);
        check("fv_count", fv_cnt, exp_fv);
        check("fe_count", fe_cnt, exp_fe);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
